// File: rtl/aib_axi_pkg.sv
// Shared link-sequencer types for the AIB-AXI bridge.
// Link state encoding as seen on link_state.
package aib_axi_pkg;

  localparam int LINK_STATE_W = 3;

  typedef enum logic [LINK_STATE_W-1:0] {
    LS_IDLE       = 3'd0,
    LS_RST_HOLD   = 3'd1,
    LS_WAIT_MAC   = 3'd2,
    LS_WAIT_ALIGN = 3'd3,
    LS_CRED_LOAD  = 3'd4,
    LS_ACTIVE     = 3'd5,
    LS_ERROR      = 3'd6
  } link_state_e;

endpackage

// File: rtl/aib_axi_credit_cnt.sv
// One flow-control credit counter: load, consume, return.
// Saturates at both ends; err is sticky until cleared.
module aib_axi_credit_cnt
  import aib_axi_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clr,
  input  logic                i_load,
  input  logic                i_en,
  input  logic [CREDIT_W-1:0] i_init,
  input  logic                i_consume,
  input  logic                i_return,
  output logic [CREDIT_W-1:0] o_count,
  output logic                o_err
);

  localparam logic [CREDIT_W-1:0] MAX = '1;

  logic [CREDIT_W-1:0] r_cnt;
  logic                r_err;
  logic                w_dec;
  logic                w_inc;

  assign w_dec = i_en & i_consume & ~i_return;
  assign w_inc = i_en & i_return & ~i_consume;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_init;
    end else if (w_dec) begin
      if (r_cnt == '0) r_err <= 1'b1;
      else             r_cnt <= r_cnt - 1'b1;
    end else if (w_inc) begin
      if (r_cnt == MAX) r_err <= 1'b1;
      else              r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_count = r_cnt;
  assign o_err   = r_err;

endmodule

// File: rtl/aib_axi_link_seq.sv
// AIB link bring-up sequencer and credit manager.
// Optional macro AIB_LINK_RETRAIN_EN: retrain on alignment loss.
module aib_axi_link_seq
  import aib_axi_pkg::*;
#(
  parameter int NBR_CHNLS    = 24,
  parameter int ACTIVE_CHNLS = 1,
  parameter int NUM_CRED     = 3,
  parameter int CREDIT_W     = 8,
  parameter int RST_HOLD     = 16,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic                         clk_wr,
  input  logic                         rst_wr_n,
  input  logic                         link_en,
  input  logic [NBR_CHNLS-1:0]         fs_mac_rdy,
  input  logic [NBR_CHNLS-1:0]         m_rx_align_done,
  input  logic [NUM_CRED*CREDIT_W-1:0] init_credit,
  input  logic [NUM_CRED-1:0]          cred_consume,
  input  logic [NUM_CRED-1:0]          cred_return,
  output logic [NBR_CHNLS-1:0]         ns_adapter_rstn,
  output logic [NBR_CHNLS-1:0]         ns_mac_rdy,
  output logic [NUM_CRED-1:0]          cred_avail,
  output logic [NUM_CRED*CREDIT_W-1:0] cred_count,
  output logic                         link_up,
  output logic [LINK_STATE_W-1:0]      link_state,
  output logic                         timeout_err,
  output logic                         cred_err
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [NBR_CHNLS:0] ONE_X  = {{NBR_CHNLS{1'b0}}, 1'b1};
  localparam logic [NBR_CHNLS:0] MASK_X = (ONE_X << ACTIVE_CHNLS) - ONE_X;
  localparam logic [NBR_CHNLS-1:0] ACT_MASK = MASK_X[NBR_CHNLS-1:0];

  link_state_e           r_state;
  logic [HOLD_W-1:0]     r_hold;
  logic [TO_W-1:0]       r_tmr;
  logic [NBR_CHNLS-1:0]  r_rstn;
  logic [NBR_CHNLS-1:0]  r_mac;
  logic                  r_up;
  logic                  r_to_err;

  logic                  w_mac_ok;
  logic                  w_align_ok;
  logic                  w_drop;
  logic                  w_clr;
  logic                  w_load;
  logic                  w_en;
  logic [NUM_CRED-1:0]   w_err;

  // Inactive channels are forced true so only active ones gate progress.
  assign w_mac_ok   = &(fs_mac_rdy | ~ACT_MASK);
  assign w_align_ok = &(m_rx_align_done | ~ACT_MASK);

`ifdef AIB_LINK_RETRAIN_EN
  assign w_drop = (r_state == LS_ACTIVE) & ~w_align_ok;
`else
  assign w_drop = 1'b0;
`endif

  assign w_clr  = ~link_en | (r_state == LS_IDLE) | w_drop;
  assign w_load = link_en & (r_state == LS_CRED_LOAD);
  assign w_en   = link_en & (r_state == LS_ACTIVE);

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      r_state  <= LS_IDLE;
      r_hold   <= '0;
      r_tmr    <= '0;
      r_rstn   <= '0;
      r_mac    <= '0;
      r_up     <= 1'b0;
      r_to_err <= 1'b0;
    end else if (!link_en) begin
      r_state  <= LS_IDLE;
      r_hold   <= '0;
      r_tmr    <= '0;
      r_rstn   <= '0;
      r_mac    <= '0;
      r_up     <= 1'b0;
      r_to_err <= 1'b0;
    end else begin
      unique case (r_state)
        LS_IDLE: begin
          r_hold   <= '0;
          r_to_err <= 1'b0;
          r_state  <= LS_RST_HOLD;
        end
        LS_RST_HOLD: begin
          if (r_hold == HOLD_LAST) begin
            r_state <= LS_WAIT_MAC;
            r_rstn  <= ACT_MASK;
            r_mac   <= ACT_MASK;
            r_tmr   <= '0;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        LS_WAIT_MAC: begin
          if (w_mac_ok) begin
            r_state <= LS_WAIT_ALIGN;
            r_tmr   <= r_tmr + 1'b1;
          end else if (r_tmr >= TO_LAST) begin
            r_state  <= LS_ERROR;
            r_to_err <= 1'b1;
            r_rstn   <= '0;
            r_mac    <= '0;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        LS_WAIT_ALIGN: begin
          if (w_align_ok) begin
            r_state <= LS_CRED_LOAD;
          end else if (r_tmr >= TO_LAST) begin
            r_state  <= LS_ERROR;
            r_to_err <= 1'b1;
            r_rstn   <= '0;
            r_mac    <= '0;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        LS_CRED_LOAD: begin
          r_state <= LS_ACTIVE;
          r_up    <= 1'b1;
        end
        LS_ACTIVE: begin
          if (w_drop) begin
            r_state <= LS_WAIT_ALIGN;
            r_up    <= 1'b0;
            r_tmr   <= '0;
          end
        end
        LS_ERROR: begin
          r_state <= LS_ERROR;
        end
        default: begin
          r_state <= LS_IDLE;
        end
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CRED; g++) begin : g_cred
      aib_axi_credit_cnt #(
        .CREDIT_W (CREDIT_W)
      ) u_cnt (
        .i_clk     (clk_wr),
        .i_rst_n   (rst_wr_n),
        .i_clr     (w_clr),
        .i_load    (w_load),
        .i_en      (w_en),
        .i_init    (init_credit[g*CREDIT_W +: CREDIT_W]),
        .i_consume (cred_consume[g]),
        .i_return  (cred_return[g]),
        .o_count   (cred_count[g*CREDIT_W +: CREDIT_W]),
        .o_err     (w_err[g])
      );
      assign cred_avail[g] =
        r_up & (|cred_count[g*CREDIT_W +: CREDIT_W]);
    end
  endgenerate

  assign ns_adapter_rstn = r_rstn;
  assign ns_mac_rdy      = r_mac;
  assign link_up         = r_up;
  assign link_state      = r_state;
  assign timeout_err     = r_to_err;
  assign cred_err        = |w_err;

endmodule
